tx_fifo_feeder: RTL and testbench
=================================

TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, data bits per entry.
REQ-003 clk  input  1  single clock for all state; rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 wr_en  input  1  host write strobe, one entry per cycle when high.
REQ-006 wr_data  input  WIDTH  byte written on wr_en.
REQ-007 full  output  1  high when count == DEPTH.
REQ-008 empty  output  1  high when count == 0.
REQ-009 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 tx_busy  input  1  busy flag from the downstream transmitter.
REQ-012 tx_start  output  1  start request to the transmitter.
REQ-013 data_out  output  WIDTH  byte presented to the transmitter data_in.

Function
REQ-014 Storage SHALL be a circular buffer with wr_ptr, rd_ptr and count; pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 A write SHALL be accepted when wr_en=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-016 wr_en=1 with count==DEPTH and no same-cycle pop SHALL drop the data, leave state unchanged and pulse overflow for exactly one cycle.
REQ-017 count SHALL be updated as +1 for a push only, -1 for a pop only, and unchanged for a simultaneous push and pop.
REQ-018 The FSM SHALL have three states: IDLE, START and DRAIN.
REQ-019 IDLE: tx_start=0; the FSM SHALL go to START when empty=0 and tx_busy=0.
REQ-020 START: tx_start=1 and data_out=mem[rd_ptr]; the FSM SHALL hold until tx_busy=1, then pop one entry in that cycle and go to DRAIN.
REQ-021 DRAIN: tx_start=0; the FSM SHALL go to IDLE when tx_busy=0.
REQ-022 data_out SHALL stay stable for the whole time tx_start is high.
REQ-023 Latency: a write accepted at edge N into an empty FIFO with an idle transmitter SHALL raise tx_start after edge N+1.
REQ-024 Pops SHALL occur only in START; an empty FIFO SHALL never be popped.
REQ-025 A write into an empty FIFO while the FSM is in DRAIN SHALL be held until DRAIN exits; bytes SHALL be sent in write order with none lost or duplicated.
REQ-026 full, empty and count SHALL be registered-consistent, reflecting state after the most recent edge.

Reset
REQ-027 When reset_n=0, the block SHALL set, immediately and without waiting for clk: FSM=IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, tx_start=0, data_out=0.
REQ-028 Reset asserted in START or DRAIN SHALL abort the transfer, discard all queued entries and deassert tx_start in the same instant.
REQ-029 Memory contents need not be reset.
REQ-030 After reset_n deasserts, the first write SHALL be accepted at the first rising edge of clk.

Structure
REQ-031 The FSM state enum and the default DEPTH and WIDTH constants SHALL live in a shared package, uart_pkg, which transmitter and receiver code may also import.
REQ-032 The storage SHALL be one sub-module, sync_fifo (push, pop, full, empty, count), with the feeder FSM in the top module.
REQ-033 The block SHALL instantiate no transmitter; it connects to the transmitter only through tx_start, data_out and tx_busy.

Verification
REQ-034 Single byte: write 8'h4D into an empty FIFO, transmitter model asserts tx_busy 1 cycle after tx_start for 160 cycles -> exactly one tx_start window with data_out=8'h4D, count returns to 0, empty=1.
REQ-035 Burst order: write 8'h01..8'h08 back-to-back -> full=1 after the 8th write; transmitter sees 01..08 in order; each tx_start begins only after tx_busy falls.
REQ-036 Overflow: fill 8 entries with tx_busy held 1, then write 8'hFF -> overflow pulses one cycle, count stays 8, 8'hFF is never transmitted.
REQ-037 Full with simultaneous pop: with count=8 in START, write 8'hAA in the cycle tx_busy rises -> write accepted, count stays 8, no overflow, 8'hAA sent last.
REQ-038 Reset mid-operation: assert reset_n=0 mid-clock while in START with count=3 -> tx_start=0, count=0 and empty=1 before the next edge; after release, a write of 8'h5A transmits normally.
REQ-039 Wrap-around: run 20 writes and sends interleaved -> pointers wrap at least twice and the received sequence matches the written sequence.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default sizing for feeder, transmitter and receiver
package uart_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/tx_fifo_feeder_if.sv
// rtl/tx_fifo_feeder_if.sv - host write port and transmitter handshake bundle for tx_fifo_feeder
interface tx_fifo_feeder_if import uart_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             tx_busy;
    logic             tx_start;
    logic [WIDTH-1:0] data_out;

    // master is the host plus transmitter side, slave is the feeder itself
    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_start, data_out
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_start, data_out
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-buffer byte store with same-cycle push/pop and overflow pulse
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok   = pop && (count != '0);
    // a full buffer still takes a write when the head slot is freed in the same cycle
    assign push_ok  = push && ((count != CW'(DEPTH)) || pop_ok);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // power-of-two DEPTH lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_fifo_feeder.sv
// rtl/tx_fifo_feeder.sv - byte FIFO feeding a UART transmitter via tx_start/tx_busy handshake
module tx_fifo_feeder import uart_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    tx_fifo_feeder_if.slave  bus
);
    feeder_state_t      state;
    logic               tx_start_q;
    logic [WIDTH-1:0]   data_out_q;
    logic               pop;
    logic [WIDTH-1:0]   head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic               fifo_overflow;

    // the transmitter taking the byte is the only event that consumes an entry
    assign pop = (state == START) && bus.tx_busy;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_overflow)
    );

    // data_out is latched on entry to START so it cannot move while tx_start is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_start_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && !bus.tx_busy) begin
                        state      <= START;
                        tx_start_q <= 1'b1;
                        data_out_q <= head_data;
                    end
                end
                START: begin
                    if (bus.tx_busy) begin
                        state      <= DRAIN;
                        tx_start_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = fifo_overflow;
    assign bus.tx_start = tx_start_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// tb/tb_tx_fifo_feeder.sv - scoreboard bench for tx_fifo_feeder with a cycle-stepped transmitter model
module tb_tx_fifo_feeder;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tx_fifo_feeder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    tx_fifo_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic model_busy = 1'b0;
    logic manual_busy = 1'b0;
    assign bus.tx_busy = model_busy | manual_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    logic [7:0] exp_q [$];

    bit   model_en = 1'b1;
    int   busy_len = 4;
    int   m_phase  = 0;
    int   m_cnt    = 0;
    logic [7:0] m_data = 8'h00;

    // one clock of time plus one tick of the transmitter model, sampled at the falling edge
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        if (model_en) begin
            case (m_phase)
                0: begin
                    if (bus.tx_start === 1'b1) begin
                        n_sent++;
                        m_data = bus.data_out;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL tx_data: sent %h, required no transfer", bus.data_out);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.data_out !== e) begin
                                n_fail++;
                                $display("FAIL tx_data: sent %h, required %h", bus.data_out, e);
                            end
                        end
                        m_phase = 1;
                    end
                end
                1: begin
                    n_checks++;
                    if (bus.tx_start !== 1'b1 || bus.data_out !== m_data) begin
                        n_fail++;
                        $display("FAIL tx_stable: tx_start=%b data_out=%h, required 1 %h",
                                 bus.tx_start, bus.data_out, m_data);
                    end
                    model_busy = 1'b1;
                    m_cnt      = busy_len;
                    m_phase    = 2;
                end
                default: begin
                    n_checks++;
                    if (bus.tx_start !== 1'b0) begin
                        n_fail++;
                        $display("FAIL start_while_busy: tx_start=%b, required 0", bus.tx_start);
                    end
                    m_cnt--;
                    if (m_cnt == 0) begin
                        model_busy = 1'b0;
                        m_phase    = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input bit track);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (track) exp_q.push_back(d);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int k = 0;
        while (!(exp_q.size() == 0 && m_phase == 0 && bus.empty === 1'b1 &&
                 bus.tx_start === 1'b0) && k < budget) begin
            step();
            k++;
        end
        repeat (3) step();
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: %0d bytes still pending, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.full, bus.empty, bus.count, bus.overflow, bus.tx_start, bus.data_out} !==
            {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: full=%b empty=%b count=%0d ovf=%b start=%b data=%h, required 0 1 0 0 0 00",
                     bus.full, bus.empty, bus.count, bus.overflow, bus.tx_start, bus.data_out);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int s0 = n_sent;
        busy_len = 160;
        write_byte(8'h4D, 1'b1);
        n_checks++;
        if (bus.count !== 4'd1 || bus.empty !== 1'b0 || bus.tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_first_edge: count=%0d empty=%b start=%b, required 1 0 0",
                     bus.count, bus.empty, bus.tx_start);
        end
        step();
        n_checks++;
        if (bus.tx_start !== 1'b1 || bus.data_out !== 8'h4D) begin
            n_fail++;
            $display("FAIL single_latency: start=%b data=%h, required 1 4d", bus.tx_start, bus.data_out);
        end
        wait_drain(400, "single");
        n_checks++;
        if (n_sent - s0 != 1 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done: sent=%0d count=%0d empty=%b, required 1 0 1",
                     n_sent - s0, bus.count, bus.empty);
        end
    endtask

    task automatic test_burst();
        int s0 = n_sent;
        busy_len    = 4;
        manual_busy = 1'b1;
        for (int i = 1; i <= 8; i++) write_byte(8'(i), 1'b1);
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_full: full=%b count=%0d start=%b, required 1 8 0",
                     bus.full, bus.count, bus.tx_start);
        end
        manual_busy = 1'b0;
        wait_drain(300, "burst");
        n_checks++;
        if (n_sent - s0 != 8) begin
            n_fail++;
            $display("FAIL burst_count: sent=%0d, required 8", n_sent - s0);
        end
    endtask

    task automatic test_overflow();
        int s0 = n_sent;
        manual_busy = 1'b1;
        for (int i = 0; i < 8; i++) write_byte(8'hC0 + 8'(i), 1'b1);
        write_byte(8'hFF, 1'b0);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 4'd8 || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_pulse: ovf=%b count=%0d full=%b, required 1 8 1",
                     bus.overflow, bus.count, bus.full);
        end
        step();
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.count !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow_one_cycle: ovf=%b count=%0d, required 0 8", bus.overflow, bus.count);
        end
        manual_busy = 1'b0;
        wait_drain(300, "overflow");
        n_checks++;
        if (n_sent - s0 != 8) begin
            n_fail++;
            $display("FAIL overflow_count: sent=%0d, required 8", n_sent - s0);
        end
    endtask

    task automatic test_full_pop();
        int s0 = n_sent;
        int k  = 0;
        manual_busy = 1'b1;
        for (int i = 0; i < 8; i++) write_byte(8'hD0 + 8'(i), 1'b1);
        manual_busy = 1'b0;
        while (model_busy !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= 20 || bus.tx_start !== 1'b1 || bus.count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_pop_setup: waited=%0d start=%b count=%0d, required <20 1 8",
                     k, bus.tx_start, bus.count);
        end
        write_byte(8'hAA, 1'b1);
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_pop_accept: ovf=%b count=%0d, required 0 8", bus.overflow, bus.count);
        end
        wait_drain(300, "full_pop");
        n_checks++;
        if (n_sent - s0 != 9) begin
            n_fail++;
            $display("FAIL full_pop_count: sent=%0d, required 9", n_sent - s0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        model_en = 1'b0;
        for (int i = 1; i <= 3; i++) write_byte(8'hE0 + 8'(i), 1'b0);
        n_checks++;
        if (bus.tx_start !== 1'b1 || bus.count !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_mid_setup: start=%b count=%0d, required 1 3", bus.tx_start, bus.count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.tx_start !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_async: start=%b count=%0d empty=%b data=%h, required 0 0 1 00",
                     bus.tx_start, bus.count, bus.empty, bus.data_out);
        end
        exp_q.delete();
        @(negedge clk);
        reset_n  = 1'b1;
        model_en = 1'b1;
        m_phase  = 0;
        s0       = n_sent;
        write_byte(8'h5A, 1'b1);
        wait_drain(200, "reset_mid");
        n_checks++;
        if (n_sent - s0 != 1) begin
            n_fail++;
            $display("FAIL reset_mid_resume: sent=%0d, required 1", n_sent - s0);
        end
    endtask

    task automatic test_wrap();
        int s0 = n_sent;
        busy_len = 2;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i * 37 + 11), 1'b1);
            repeat ((i % 3) * 5) step();
        end
        wait_drain(400, "wrap");
        n_checks++;
        if (n_sent - s0 != 20 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count: sent=%0d ovf=%b, required 20 0", n_sent - s0, bus.overflow);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
